// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests under a credit
// cap of DEPTH, queues returned instructions for decode and flushes on taken-branch redirects.
//   state | meaning
//   BOOT  | first cycle after reset release, loads startpc
//   RUN   | fetching; responses are pushed into the queue
//   FLUSH | discarding responses to requests issued before the last redirect
module fetch_unit #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [ADDR_W-1:0]  startpc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic [10:0]        opcode,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  fetch_pc_q, rsp_pc_q;
  logic [CW-1:0]      count_q, outst_q, drop_q;
  logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [INSTR_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0]  q_pc   [DEPTH];

  logic          req_fire, rsp_fire, push, pop;
  logic [CW-1:0] drop_next;
  logic [CW:0]   inflight;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign inflight       = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = (state_q == RUN) && !redirect && (inflight < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding (e.g. stale across a reset) is ignored.
  assign rsp_fire       = imem_rsp_valid && (state_q != BOOT) && (outst_q != '0);
  assign drop_next      = outst_q - CW'(rsp_fire);
  assign push           = rsp_fire && (drop_q == '0) && !redirect;

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready && !redirect;
  assign inst       = inst_valid ? q_data[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr_q] : '0;
  assign opcode     = inst[31:21];

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q    <= BOOT;
      fetch_pc_q <= '0;
      rsp_pc_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (state_q == BOOT) begin
      state_q    <= RUN;
      fetch_pc_q <= startpc & PC_MASK;
      rsp_pc_q   <= startpc & PC_MASK;
    end else if (redirect) begin
      // Everything still in flight becomes stale; requests are masked this cycle.
      state_q    <= (drop_next != '0) ? FLUSH : RUN;
      fetch_pc_q <= redirect_pc & PC_MASK;
      rsp_pc_q   <= redirect_pc & PC_MASK;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      outst_q    <= drop_next;
      drop_q     <= drop_next;
    end else begin
      if (req_fire) fetch_pc_q <= fetch_pc_q + PC_STEP;
      outst_q <= outst_q + CW'(req_fire) - CW'(rsp_fire);
      if (rsp_fire && (drop_q != '0)) begin
        drop_q <= drop_q - CW'(1);
        if (drop_q == CW'(1)) state_q <= RUN;
      end
      if (push) begin
        rsp_pc_q <= rsp_pc_q + PC_STEP;
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_data[wr_ptr_q] <= imem_rsp_data;
      q_pc[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order imem model with variable latency, plus a reference that
// expects the request and delivered-instruction streams to walk PC+4 from each (re)start point.
module tb_fetch_unit;
  localparam int AW = 64;
  localparam int IW = 32;
  localparam int D  = 2;

  logic          CLK = 1'b0;
  logic          resetl;
  logic [AW-1:0] startpc;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          inst_valid, inst_ready;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic [10:0]   opcode;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  always #5 CLK = ~CLK;

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D)) dut (
    .CLK(CLK), .resetl(resetl), .startpc(startpc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  typedef struct {
    logic [AW-1:0] start;
    logic [AW-1:0] word_addr;
    logic [IW-1:0] word;
    logic [AW-1:0] exp_pc;
    logic [10:0]   exp_op;
  } vec_t;

  pend_t         pend[$];
  int            checks = 0, errors = 0;
  int            cyc = 0, lat = 1, last_due = 0, n_req = 0, n_pop = 0;
  logic [AW-1:0] exp_req, exp_pc;
  logic [AW-1:0] ovr_addr = 64'h1;
  logic [IW-1:0] ovr_word = '0;
  bit            in_boot = 1'b1, force_stale = 1'b0;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == ovr_addr) return ovr_word;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One clock cycle: drive this cycle's imem response, check the settled cycle, then clock.
  task automatic tick();
    int d;
    if (force_stale) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (!resetl) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      pend.delete();
      exp_req  = startpc & ~64'd3;
      exp_pc   = exp_req;
      in_boot  = 1'b1;
      last_due = 0;
    end else begin
      if (in_boot) chk("boot_req_valid", imem_req_valid, 0);
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req);
        exp_req += 64'd4;
        n_req++;
        d = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        pend.push_back('{imem_req_addr, d});
        last_due = d;
      end
      chk("credit_cap", pend.size() <= D, 1);
      if (!inst_valid) begin
        chk("empty_inst", inst, 0);
        chk("empty_pc", inst_pc, 0);
      end
      if (redirect && !in_boot) begin
        chk("redir_masks_req", imem_req_valid, 0);
        exp_req = redirect_pc & ~64'd3;
        exp_pc  = exp_req;
      end else if (inst_valid && inst_ready) begin
        chk("pop_pc", inst_pc, exp_pc);
        chk("pop_inst", inst, mem_word(exp_pc));
        chk("pop_opcode", opcode, mem_word(exp_pc) >> 21);
        exp_pc += 64'd4;
        n_pop++;
      end
      in_boot = 1'b0;
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return imem_req_valid && imem_req_ready;
      1: return inst_valid;
      2: return n_req >= 2;
      3: return inst_valid && pend.size() > 0 && pend[0].due <= cyc;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string name);
    int i = 0;
    while (!cond(which) && i < budget) begin
      tick();
      i++;
    end
    checks++;
    if (!cond(which)) begin
      errors++;
      $display("FAIL %s: condition not reached within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset(input logic [AW-1:0] start);
    startpc        = start;
    resetl         = 1'b0;
    redirect       = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    force_stale    = 1'b0;
    tick();
    tick();
    resetl = 1'b1;
    n_req  = 0;
    n_pop  = 0;
  endtask

  initial begin
    vec_t          vt[5];
    logic [AW-1:0] t1_addr[3];
    int            k, j;

    vt[0] = '{64'h100, 64'h100, 32'hF840_03E9, 64'h100, 11'h7C2};
    vt[1] = '{64'h203, 64'h200, 32'h8B00_0000, 64'h200, 11'h458};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFC, 11'h7FF};
    vt[3] = '{64'h7, 64'h4, 32'h0020_0000, 64'h4, 11'h001};
    vt[4] = '{64'hDEAD_BEEF_0000_1001, 64'hDEAD_BEEF_0000_1000, 32'h1234_5678,
              64'hDEAD_BEEF_0000_1000, 11'h091};
    t1_addr = '{64'h100, 64'h104, 64'h108};

    resetl = 1'b0; startpc = '0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge CLK);

    // boot PC masking, first request/instruction, opcode extraction
    for (int v = 0; v < 5; v++) begin
      ovr_addr = vt[v].word_addr;
      ovr_word = vt[v].word;
      do_reset(vt[v].start);
      imem_req_ready = 1'b1;
      lat = 1;
      wait_for(0, 4, "tv_req");
      chk("tv_req_addr", imem_req_addr, vt[v].exp_pc);
      wait_for(1, 6, "tv_inst");
      chk("tv_inst_pc", inst_pc, vt[v].exp_pc);
      chk("tv_inst", inst, vt[v].word);
      chk("tv_opcode", opcode, vt[v].exp_op);
      repeat (4) tick();
    end

    // streaming from 0x100 with a 1-cycle imem
    ovr_addr = 64'h104; ovr_word = 32'hF840_03E9;
    do_reset(64'h100);
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    k = 0; j = 0;
    repeat (14) begin
      if (imem_req_valid && imem_req_ready && k < 3) begin
        chk("t1_req_addr", imem_req_addr, t1_addr[k]);
        k++;
      end
      if (inst_valid && j < 3) begin
        chk("t1_inst_pc", inst_pc, t1_addr[j]);
        if (j == 1) chk("t1_opcode", opcode, 11'h7C2);
        j++;
      end
      tick();
    end
    chk("t1_req_count", k, 3);
    chk("t1_pop_count", j, 3);

    // decode stalled: credits exhaust at two queued entries
    do_reset(64'h100);
    imem_req_ready = 1'b1; lat = 1;
    repeat (8) tick();
    chk("t2_req_valid", imem_req_valid, 0);
    chk("t2_n_req", n_req, 2);
    chk("t2_inst_valid", inst_valid, 1);
    chk("t2_inst_pc", inst_pc, 64'h100);
    inst_ready = 1'b1;
    wait_for(0, 4, "t2_resume");
    chk("t2_next_addr", imem_req_addr, 64'h108);
    repeat (10) tick();
    chk("t2_pops", n_pop >= 4, 1);

    // redirect with two outstanding: both responses dropped
    do_reset(64'h100);
    imem_req_ready = 1'b1; lat = 3;
    wait_for(2, 8, "t3_two_out");
    redirect = 1'b1; redirect_pc = 64'h203; inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    wait_for(0, 12, "t3_refetch");
    chk("t3_flush_done", pend.size(), 0);
    chk("t3_refetch_addr", imem_req_addr, 64'h200);
    wait_for(1, 10, "t3_inst");
    chk("t3_first_pc", inst_pc, 64'h200);
    repeat (6) tick();

    // redirect coinciding with a response and a pop
    do_reset(64'h100);
    imem_req_ready = 1'b1; lat = 1;
    wait_for(3, 8, "t4_setup");
    redirect = 1'b1; redirect_pc = 64'h302; inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    chk("t4_inst_valid", inst_valid, 0);
    chk("t4_req_valid", imem_req_valid, 1);
    chk("t4_req_addr", imem_req_addr, 64'h300);
    repeat (8) tick();

    // request held under backpressure
    do_reset(64'h100);
    inst_ready = 1'b1; lat = 2;
    tick();
    repeat (3) begin
      chk("t5_hold_valid", imem_req_valid, 1);
      chk("t5_hold_addr", imem_req_addr, 64'h100);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    chk("t5_after_fire", imem_req_addr, 64'h104);
    repeat (6) tick();

    // reset in the middle of a flush, stale responses afterwards
    do_reset(64'h100);
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 4;
    wait_for(2, 8, "t6_two_out");
    redirect = 1'b1; redirect_pc = 64'h400;
    tick();
    redirect = 1'b0;
    tick();
    startpc = 64'h500;
    resetl  = 1'b0;
    #1;
    chk("t6_rst_req_valid", imem_req_valid, 0);
    chk("t6_rst_req_addr", imem_req_addr, 0);
    chk("t6_rst_inst_valid", inst_valid, 0);
    chk("t6_rst_inst_pc", inst_pc, 0);
    chk("t6_rst_opcode", opcode, 0);
    tick();
    resetl = 1'b1; redirect = 1'b1; redirect_pc = 64'h900; force_stale = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    force_stale = 1'b0;
    wait_for(1, 10, "t6_inst");
    chk("t6_first_pc", inst_pc, 64'h500);
    chk("t6_first_inst", inst, mem_word(64'h500));
    repeat (6) tick();

    // random traffic against the reference
    ovr_addr = 64'h1;
    do_reset({$urandom, $urandom});
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(3) != 0);
      inst_ready     = ($urandom_range(2) != 0);
      if ($urandom_range(15) == 0) lat = 1 + $urandom_range(3);
      redirect = ($urandom_range(19) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15)))
                                             : {$urandom, $urandom};
      tick();
    end
    redirect = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (30) tick();
    chk("rand_progress", n_pop > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
